// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and jump-handshake initiator
module pc_sequencer #(
   parameter int                PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                rst,
   // retire interface from the control FSM
   input  logic                instr_done,
   input  logic                is_jump,
   // jump unit handshake
   output logic                jmp_en,
   output logic [PC_WIDTH-1:0] jmp_pc,
   input  logic [PC_WIDTH-1:0] jmp_target,
   input  logic                jmp_done,
   // fetch interface
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_valid,
   output logic                fault
);

   // Counter only has to reach TIMEOUT-1, so it can never overflow.
   localparam int CNT_W = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t              state, state_n;
   logic [PC_WIDTH-1:0] pc_n;
   logic [PC_WIDTH-1:0] jmp_pc_n;
   logic                pc_valid_n;
   logic                jmp_en_n;
   logic                fault_n;
   logic [CNT_W-1:0]    cnt, cnt_n;

   // State and all output registers; reset overrides every state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RUN;
         pc       <= RESET_PC;
         pc_valid <= 1'b0;
         jmp_en   <= 1'b0;
         jmp_pc   <= '0;
         fault    <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         pc_valid <= pc_valid_n;
         jmp_en   <= jmp_en_n;
         jmp_pc   <= jmp_pc_n;
         fault    <= fault_n;
         cnt      <= cnt_n;
      end
   end

   // Next-state and next-output decode; jmp_en defaults low so it is a one-cycle pulse.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      pc_valid_n = pc_valid;
      jmp_en_n   = 1'b0;
      jmp_pc_n   = jmp_pc;
      fault_n    = fault;
      cnt_n      = cnt;

      case (state)
         S_RUN: begin
            // pc is usable whenever we are running and not handing off to the jump unit
            pc_valid_n = 1'b1;
            if (instr_done) begin
               if (is_jump) begin
                  jmp_pc_n   = pc;
                  jmp_en_n   = 1'b1;
                  pc_valid_n = 1'b0;
                  state_n    = S_REQ;
               end else begin
                  pc_n = pc + PC_WIDTH'(1);
               end
            end
         end

         S_REQ: begin
            // one-cycle slot that lets the jump unit see jmp_en before we sample jmp_done
            pc_valid_n = 1'b0;
            cnt_n      = '0;
            state_n    = S_WAIT;
         end

         S_WAIT: begin
            pc_valid_n = 1'b0;
            if (jmp_done) begin
               // a target equal to the jump's own PC means "fall through"; never self-loop
               state_n    = S_RUN;
               pc_valid_n = 1'b1;
               if (jmp_target == jmp_pc) begin
                  pc_n = jmp_pc + PC_WIDTH'(1);
               end else begin
                  pc_n = jmp_target;
               end
            end else if (cnt == CNT_LAST) begin
               state_n = S_FAULT;
               fault_n = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end

         S_FAULT: begin
            // frozen until reset
            pc_valid_n = 1'b0;
            fault_n    = 1'b1;
         end

         default: begin
            state_n    = S_RUN;
            pc_valid_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        instr_done;
   logic        is_jump;
   logic        jmp_done;
   logic [31:0] jmp_target;

   logic        jmp_en0, pc_valid0, fault0;
   logic [31:0] jmp_pc0, pc0;
   logic        jmp_en1, pc_valid1, fault1;
   logic [31:0] jmp_pc1, pc1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        done;
      logic        jmp;
      logic        jdone;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic        e_pv;
      logic        e_en;
      logic [31:0] e_jpc;
      logic        e_f;
      logic        chk1;
      logic [31:0] e_pc1;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(15)) dut0 (
      .clk(clk), .rst(rst), .instr_done(instr_done), .is_jump(is_jump),
      .jmp_en(jmp_en0), .jmp_pc(jmp_pc0), .jmp_target(jmp_target), .jmp_done(jmp_done),
      .pc(pc0), .pc_valid(pc_valid0), .fault(fault0)
   );

   pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFE), .TIMEOUT(15)) dut1 (
      .clk(clk), .rst(rst), .instr_done(instr_done), .is_jump(is_jump),
      .jmp_en(jmp_en1), .jmp_pc(jmp_pc1), .jmp_target(jmp_target), .jmp_done(jmp_done),
      .pc(pc1), .pc_valid(pc_valid1), .fault(fault1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic d, input logic j, input logic jd,
                               input logic [31:0] t, input logic [31:0] epc, input logic epv,
                               input logic een, input logic [31:0] ejpc, input logic ef,
                               input logic c1, input logic [31:0] epc1);
      vec_t v;
      v.rst = r; v.done = d; v.jmp = j; v.jdone = jd; v.tgt = t;
      v.e_pc = epc; v.e_pv = epv; v.e_en = een; v.e_jpc = ejpc; v.e_f = ef;
      v.chk1 = c1; v.e_pc1 = epc1;
      return v;
   endfunction

   task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   // Drive one vector, push its expectation, then pop and compare after the edge.
   task automatic cyc(input vec_t v, input int step);
      vec_t e;
      @(negedge clk);
      rst        = v.rst;
      instr_done = v.done;
      is_jump    = v.jmp;
      jmp_done   = v.jdone;
      jmp_target = v.tgt;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", step, pc0, e.e_pc);
      chk("pc_valid", step, 32'(pc_valid0), 32'(e.e_pv));
      chk("jmp_en", step, 32'(jmp_en0), 32'(e.e_en));
      chk("jmp_pc", step, jmp_pc0, e.e_jpc);
      chk("fault", step, 32'(fault0), 32'(e.e_f));
      if (e.chk1) chk("pc_wrap", step, pc1, e.e_pc1);
   endtask

   initial begin
      int step;
      rst = 1'b1; instr_done = 1'b0; is_jump = 1'b0; jmp_done = 1'b0; jmp_target = '0;

      //            rst d j jd tgt           pc          pv en jpc        f  c1 pc1
      tbl.push_back(mk(1,0,0,0,32'h0,  32'h0,  0,0,32'h0,  0, 1,32'hFFFF_FFFE));
      tbl.push_back(mk(1,1,1,1,32'h0,  32'h0,  0,0,32'h0,  0, 1,32'hFFFF_FFFE));
      tbl.push_back(mk(0,1,0,0,32'h0,  32'h1,  1,0,32'h0,  0, 1,32'hFFFF_FFFF));
      tbl.push_back(mk(0,1,0,0,32'h0,  32'h2,  1,0,32'h0,  0, 1,32'h0000_0000));
      tbl.push_back(mk(0,1,0,0,32'h0,  32'h3,  1,0,32'h0,  0, 1,32'h0000_0001));
      tbl.push_back(mk(0,1,1,0,32'h0,  32'h3,  0,1,32'h3,  0, 0,32'h0));
      tbl.push_back(mk(0,0,0,0,32'h0,  32'h3,  0,0,32'h3,  0, 0,32'h0));
      tbl.push_back(mk(0,0,0,1,32'h10, 32'h10, 1,0,32'h3,  0, 0,32'h0));
      tbl.push_back(mk(0,1,1,0,32'h0,  32'h10, 0,1,32'h10, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,0,32'h0,  32'h10, 0,0,32'h10, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,1,32'h40, 32'h40, 1,0,32'h10, 0, 0,32'h0));
      tbl.push_back(mk(0,1,1,0,32'h0,  32'h40, 0,1,32'h40, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,0,32'h0,  32'h40, 0,0,32'h40, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,1,32'h20, 32'h20, 1,0,32'h40, 0, 0,32'h0));
      tbl.push_back(mk(0,1,1,0,32'h0,  32'h20, 0,1,32'h20, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,0,32'h20, 32'h20, 0,0,32'h20, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,1,32'h20, 32'h21, 1,0,32'h20, 0, 0,32'h0));
      tbl.push_back(mk(0,0,1,1,32'h20, 32'h21, 1,0,32'h20, 0, 0,32'h0));
      tbl.push_back(mk(0,1,1,1,32'h55, 32'h21, 0,1,32'h21, 0, 0,32'h0));
      tbl.push_back(mk(0,1,0,1,32'h55, 32'h21, 0,0,32'h21, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,1,32'h77, 32'h77, 1,0,32'h21, 0, 0,32'h0));
      tbl.push_back(mk(0,1,0,0,32'h0,  32'h78, 1,0,32'h21, 0, 0,32'h0));

      step = 0;
      foreach (tbl[i]) begin
         cyc(tbl[i], step);
         step++;
      end

      // Jump unit never answers: fault after exactly 15 WAIT cycles, retires ignored.
      cyc(mk(0,1,1,0,32'h0, 32'h78,0,1,32'h78,0, 0,32'h0), step++);
      cyc(mk(0,0,0,0,32'h0, 32'h78,0,0,32'h78,0, 0,32'h0), step++);
      for (int k = 1; k <= 15; k++) begin
         cyc(mk(0,logic'(k & 1),0,0,32'h0, 32'h78,0,0,32'h78,logic'(k == 15), 0,32'h0), step++);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(mk(0,1,logic'(k & 1),1,32'h5, 32'h78,0,0,32'h78,1, 0,32'h0), step++);
      end
      cyc(mk(1,1,1,1,32'h5, 32'h0,0,0,32'h0,0, 0,32'h0), step++);
      cyc(mk(0,1,0,0,32'h0, 32'h1,1,0,32'h0,0, 0,32'h0), step++);

      // jmp_done arriving on the timeout cycle wins over the fault.
      cyc(mk(0,1,1,0,32'h0, 32'h1,0,1,32'h1,0, 0,32'h0), step++);
      cyc(mk(0,0,0,1,32'h0, 32'h1,0,0,32'h1,0, 0,32'h0), step++);
      for (int k = 1; k <= 14; k++) begin
         cyc(mk(0,0,0,0,32'h0, 32'h1,0,0,32'h1,0, 0,32'h0), step++);
      end
      cyc(mk(0,0,0,1,32'h99, 32'h99,1,0,32'h1,0, 0,32'h0), step++);
      cyc(mk(0,0,0,0,32'h0,  32'h99,1,0,32'h1,0, 0,32'h0), step++);

      // Reset in the middle of WAIT.
      cyc(mk(0,1,1,0,32'h0, 32'h99,0,1,32'h99,0, 0,32'h0), step++);
      cyc(mk(0,0,0,0,32'h0, 32'h99,0,0,32'h99,0, 0,32'h0), step++);
      for (int k = 0; k < 3; k++) begin
         cyc(mk(0,0,0,0,32'h0, 32'h99,0,0,32'h99,0, 0,32'h0), step++);
      end
      cyc(mk(1,0,0,1,32'h44, 32'h0,0,0,32'h0,0, 0,32'h0), step++);
      cyc(mk(0,0,0,1,32'h44, 32'h0,1,0,32'h0,0, 0,32'h0), step++);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
